// File: rtl/fp_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// fp_op_sequencer_if
// Groups every non-clock, non-reset signal of the FP operation sequencer.
//   Request side : in_valid/in_ready handshake with in_a, in_b, in_op
//   ALU side     : alu_a/alu_b/alu_op out to a combinational FP ALU,
//                  alu_result and alu_* flags back from it
//   Response side: out_valid/out_ready handshake with out_result and flags
//   Status       : clr_sticky in, sticky_ovf/sticky_unf and op_count out
// The slave modport is the sequencer itself; the master modport is the
// surrounding environment (requester, ALU and response consumer together).
// ---------------------------------------------------------------------------
interface fp_op_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [2:0]  in_op;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_overflow;
   logic        alu_underflow;
   logic        alu_gt;
   logic        alu_lt;
   logic        alu_eq;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_gt;
   logic        out_lt;
   logic        out_eq;
   logic        out_illegal;

   logic        clr_sticky;
   logic        sticky_ovf;
   logic        sticky_unf;
   logic [15:0] op_count;

   modport slave (
      input  in_valid, in_a, in_b, in_op,
      input  alu_result, alu_overflow, alu_underflow, alu_gt, alu_lt, alu_eq,
      input  out_ready, clr_sticky,
      output in_ready, alu_a, alu_b, alu_op,
      output out_valid, out_result, out_overflow, out_underflow,
      output out_gt, out_lt, out_eq, out_illegal,
      output sticky_ovf, sticky_unf, op_count
   );

   modport master (
      output in_valid, in_a, in_b, in_op,
      output alu_result, alu_overflow, alu_underflow, alu_gt, alu_lt, alu_eq,
      output out_ready, clr_sticky,
      input  in_ready, alu_a, alu_b, alu_op,
      input  out_valid, out_result, out_overflow, out_underflow,
      input  out_gt, out_lt, out_eq, out_illegal,
      input  sticky_ovf, sticky_unf, op_count
   );
endinterface

// File: rtl/fp_op_sequencer.sv
// ---------------------------------------------------------------------------
// fp_op_sequencer
// Accepts one FP request at a time, holds its operands steady on the ALU
// inputs for SETTLE_CYCLES cycles so the combinational FP ALU can settle,
// then captures the ALU outputs and presents them until the consumer takes
// them. Illegal opcodes (4-7) bypass the ALU and answer with out_illegal.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fp_op_sequencer_if slave modport (request, ALU, response, status)
// ---------------------------------------------------------------------------
module fp_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   fp_op_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [31:0] aluA_q, aluB_q;
   logic [2:0]  aluOp_q;
   logic [31:0] outResult_q;
   logic        outOverflow_q, outUnderflow_q;
   logic        outGt_q, outLt_q, outEq_q, outIllegal_q;
   logic        stickyOvf_q, stickyOvf_d;
   logic        stickyUnf_q, stickyUnf_d;
   logic [15:0] opCount_q;

   logic        inReady;
   logic        outValid;
   logic        accept;
   logic        illegalOp;
   logic        capture;
   logic        handshake;

   assign accept    = bus.in_valid && inReady;
   assign illegalOp = bus.in_op[2];
   assign capture   = (state_q == EXEC) && (cnt_q == 4'd0);
   assign handshake = outValid && bus.out_ready;

   // State register: the settle counter travels with the state so both are
   // cleared together when reset discards an in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. A new request can only be taken from IDLE or from a
   // HOLD whose response is leaving this cycle, which gives back-to-back
   // operation without a bubble. Illegal opcodes go straight to HOLD since
   // there is nothing for the ALU to compute.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = illegalOp ? HOLD : EXEC;
         end
         EXEC: begin
            if (cnt_q == 4'd0) state_d = HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         HOLD: begin
            if (bus.out_ready) state_d = accept ? (illegalOp ? HOLD : EXEC) : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) cnt_d = SETTLE_LOAD;
   end

   // Output decode. in_ready is masked by reset so a requester never sees a
   // ready while the block is being cleared.
   always_comb begin
      inReady  = 1'b0;
      outValid = 1'b0;
      case (state_q)
         IDLE:    inReady = !rst;
         HOLD:    begin
            inReady  = !rst && bus.out_ready;
            outValid = 1'b1;
         end
         default: inReady = 1'b0;
      endcase
   end

   // Sticky flags collect exceptions of responses actually handed over; a
   // clear in the same cycle as a new exception loses to the exception.
   always_comb begin
      stickyOvf_d = (handshake && outOverflow_q)  || (stickyOvf_q && !bus.clr_sticky);
      stickyUnf_d = (handshake && outUnderflow_q) || (stickyUnf_q && !bus.clr_sticky);
   end

   // Datapath registers: operand latch on accept, response capture at the
   // end of the settle window (or a synthetic illegal response), and the
   // completed-response counter which simply wraps at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aluA_q         <= '0;
         aluB_q         <= '0;
         aluOp_q        <= '0;
         outResult_q    <= '0;
         outOverflow_q  <= 1'b0;
         outUnderflow_q <= 1'b0;
         outGt_q        <= 1'b0;
         outLt_q        <= 1'b0;
         outEq_q        <= 1'b0;
         outIllegal_q   <= 1'b0;
         stickyOvf_q    <= 1'b0;
         stickyUnf_q    <= 1'b0;
         opCount_q      <= '0;
      end else begin
         if (accept) begin
            aluA_q  <= bus.in_a;
            aluB_q  <= bus.in_b;
            aluOp_q <= bus.in_op;
         end
         if (accept && illegalOp) begin
            outResult_q    <= '0;
            outOverflow_q  <= 1'b0;
            outUnderflow_q <= 1'b0;
            outGt_q        <= 1'b0;
            outLt_q        <= 1'b0;
            outEq_q        <= 1'b0;
            outIllegal_q   <= 1'b1;
         end else if (capture) begin
            outResult_q    <= bus.alu_result;
            outOverflow_q  <= bus.alu_overflow;
            outUnderflow_q <= bus.alu_underflow;
            outGt_q        <= bus.alu_gt;
            outLt_q        <= bus.alu_lt;
            outEq_q        <= bus.alu_eq;
            outIllegal_q   <= 1'b0;
         end
         stickyOvf_q <= stickyOvf_d;
         stickyUnf_q <= stickyUnf_d;
         if (handshake) opCount_q <= opCount_q + 16'd1;
      end
   end

   assign bus.in_ready      = inReady;
   assign bus.out_valid     = outValid;
   assign bus.alu_a         = aluA_q;
   assign bus.alu_b         = aluB_q;
   assign bus.alu_op        = aluOp_q;
   assign bus.out_result    = outResult_q;
   assign bus.out_overflow  = outOverflow_q;
   assign bus.out_underflow = outUnderflow_q;
   assign bus.out_gt        = outGt_q;
   assign bus.out_lt        = outLt_q;
   assign bus.out_eq        = outEq_q;
   assign bus.out_illegal   = outIllegal_q;
   assign bus.sticky_ovf    = stickyOvf_q;
   assign bus.sticky_unf    = stickyUnf_q;
   assign bus.op_count      = opCount_q;

endmodule
